flash_audio_player: RTL and testbench

- Parametrised sample player that pulls audio words from the flash reader (data/valid/next/done handshake) and streams them to the audio codec write FIFO (write_ready/write_s handshake).
- Generalises the single-shot mono player with:
  - configurable sample/codec widths;
  - mono or interleaved-stereo source;
  - playback speed modes, volume attenuation, looping, pause, and a frame counter.
- Sits between flash_reader_de2 and audio_codec in the top level.

---
 rtl/flash_audio_player.sv | 218 +++++++++++++++++++++
 tb/tb_flash_audio_player.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_audio_player.sv
// flash_audio_player: pulls samples from the flash reader and streams them to
// the audio codec write FIFO. Supports mono or interleaved stereo sources,
// half/double speed, volume attenuation by arithmetic shift, looping, pause
// and a count of frames accepted by the codec.
// Optional: define FLASH_AUDIO_PLAYER_PEAK_EN to add the `peak` output
// (largest magnitude sent since playback started).
module flash_audio_player #(
  parameter int DATA_W  = 16,
  parameter int AUDIO_W = 16,
  parameter int STEREO  = 0,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 24
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               loop,
  input  logic [1:0]         speed,
  input  logic [SHIFT_W-1:0] vol_shift,
  input  logic [DATA_W-1:0]  fl_data,
  input  logic               fl_valid,
  input  logic               fl_done,
  output logic               fl_next,
  output logic               fl_restart,
  input  logic               write_ready,
  output logic               write_s,
  output logic [AUDIO_W-1:0] writedata_left,
  output logic [AUDIO_W-1:0] writedata_right,
  output logic               playing,
  output logic               finished,
  output logic [CNT_W-1:0]   frame_count
`ifdef FLASH_AUDIO_PLAYER_PEAK_EN
  ,
  output logic [AUDIO_W-1:0] peak
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_ACCEPT,
    WAIT_READY,
    FINISHED
  } state_t;

  state_t              state;
  logic                word_sel;   // stereo: 0 = expecting L word, 1 = R word
  logic                discard;    // double speed: fetching a frame to throw away
  logic                half_q;     // half speed captured when the frame was fetched
  logic                resent;     // half speed: first copy already accepted
  logic [DATA_W-1:0]   lat_l;
  logic [DATA_W-1:0]   lat_r;
  logic                take_word;
  logic                frame_end;
  logic signed [AUDIO_W-1:0] smp_l;
  logic signed [AUDIO_W-1:0] smp_r;

  // Left-justify the flash word into the codec width: zero-fill LSBs when
  // widening, drop LSBs when narrowing. Taking the top AUDIO_W bits of the
  // word followed by AUDIO_W zeros covers both cases.
  function automatic logic signed [AUDIO_W-1:0] align(input logic [DATA_W-1:0] d);
    logic [DATA_W+AUDIO_W-1:0] ext;
    ext = {d, {AUDIO_W{1'b0}}};
    return ext[DATA_W+AUDIO_W-1 -: AUDIO_W];
  endfunction

  // Volume attenuation: arithmetic shift keeps the sign of the sample.
  function automatic logic signed [AUDIO_W-1:0] vol_scale(input logic signed [AUDIO_W-1:0] s,
                                                          input logic [SHIFT_W-1:0] sh);
    return s >>> sh;
  endfunction

  // Flash words are not trusted while the reader is still reacting to a
  // next/restart pulse: the previous word may still be on the bus.
  always_comb begin
    take_word = fl_valid && !fl_next && !fl_restart;
    frame_end = (STEREO == 0) || word_sel;
    smp_l     = vol_scale(align(lat_l), vol_shift);
    smp_r     = vol_scale(align(lat_r), vol_shift);
  end

  // Playback sequencer: fetch a frame, wait for the codec, write, repeat.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      word_sel        <= 1'b0;
      discard         <= 1'b0;
      half_q          <= 1'b0;
      resent          <= 1'b0;
      lat_l           <= '0;
      lat_r           <= '0;
      fl_next         <= 1'b0;
      fl_restart      <= 1'b0;
      write_s         <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      playing         <= 1'b0;
      finished        <= 1'b0;
      frame_count     <= '0;
    end else begin
      fl_next    <= 1'b0;
      fl_restart <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            frame_count <= '0;
            playing     <= 1'b1;
            word_sel    <= 1'b0;
            discard     <= 1'b0;
          end
        end
        FETCH: begin
          if (take_word) begin
            if (fl_done) begin
              word_sel <= 1'b0;
              if (discard) begin
                // End of data while skipping: still play the kept frame.
                discard    <= 1'b0;
                fl_restart <= loop;
                state      <= WAIT_READY;
              end else if (loop) begin
                fl_restart <= 1'b1;
              end else begin
                state    <= FINISHED;
                playing  <= 1'b0;
                finished <= 1'b1;
              end
            end else begin
              fl_next <= 1'b1;
              if (!discard) begin
                if ((STEREO == 0) || !word_sel) lat_l <= fl_data;
                if ((STEREO == 0) || word_sel)  lat_r <= fl_data;
              end
              if (!frame_end) begin
                word_sel <= 1'b1;
              end else begin
                word_sel <= 1'b0;
                if (discard) begin
                  discard <= 1'b0;
                  state   <= WAIT_READY;
                end else begin
                  half_q <= (speed == 2'b01);
                  resent <= 1'b0;
                  if (speed == 2'b10) discard <= 1'b1;
                  else                state   <= WAIT_READY;
                end
              end
            end
          end
        end
        WAIT_READY: begin
          if (!start) begin
            state   <= IDLE;
            playing <= 1'b0;
          end else if (write_ready && !pause) begin
            state <= SEND;
          end
        end
        SEND: begin
          writedata_left  <= smp_l;
          writedata_right <= smp_r;
          write_s         <= 1'b1;
          state           <= WAIT_ACCEPT;
        end
        WAIT_ACCEPT: begin
          if (!write_ready) begin
            write_s     <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
            if (half_q && !resent) begin
              resent <= 1'b1;
              state  <= WAIT_READY;
            end else begin
              state <= FETCH;
            end
          end
        end
        FINISHED: begin
          if (!start) begin
            finished <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLASH_AUDIO_PLAYER_PEAK_EN
  logic [AUDIO_W-1:0] mag_l;
  logic [AUDIO_W-1:0] mag_r;
  logic [AUDIO_W-1:0] mag_max;

  // Magnitude with the most-negative value saturated to the largest positive.
  function automatic logic [AUDIO_W-1:0] abs_sat(input logic signed [AUDIO_W-1:0] s);
    if (s == {1'b1, {(AUDIO_W-1){1'b0}}}) return {1'b0, {(AUDIO_W-1){1'b1}}};
    if (s[AUDIO_W-1]) return AUDIO_W'(-s);
    return s;
  endfunction

  // Larger magnitude of the two channels about to be sent.
  always_comb begin
    mag_l   = abs_sat(smp_l);
    mag_r   = abs_sat(smp_r);
    mag_max = (mag_l > mag_r) ? mag_l : mag_r;
  end

  // Peak hold, restarted whenever playback begins.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                           peak <= '0;
    else if (state == IDLE && start)     peak <= '0;
    else if (state == SEND && mag_max > peak) peak <= mag_max;
  end
`endif

endmodule

// File: tb/tb_flash_audio_player.sv
// Bench for flash_audio_player: a 16-bit mono instance and an 8-bit stereo
// instance, each with a flash reader model, a codec FIFO model that scores
// every accepted write against a queue built from a reference model, and a
// sequencer running directed and random playback sessions.
module tb_flash_audio_player;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_fail = 0;
  bit blk_done [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : blk
    localparam int DW = (g == 0) ? 16 : 8;
    localparam int ST = g;

    logic              reset;
    logic              start, pause, loop;
    logic [1:0]        speed;
    logic [2:0]        vol_shift;
    logic [DW-1:0]     fl_data;
    logic              fl_valid, fl_done, fl_next, fl_restart;
    logic              write_ready, write_s;
    logic [15:0]       wl, wr;
    logic              playing, finished;
    logic [23:0]       frame_count;
`ifdef FLASH_AUDIO_PLAYER_PEAK_EN
    logic [15:0]       peak;
`endif

    flash_audio_player #(
      .DATA_W(DW), .AUDIO_W(16), .STEREO(ST), .SHIFT_W(3), .CNT_W(24)
    ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause),
      .loop(loop), .speed(speed), .vol_shift(vol_shift),
      .fl_data(fl_data), .fl_valid(fl_valid), .fl_done(fl_done),
      .fl_next(fl_next), .fl_restart(fl_restart),
      .write_ready(write_ready), .write_s(write_s),
      .writedata_left(wl), .writedata_right(wr),
      .playing(playing), .finished(finished), .frame_count(frame_count)
`ifdef FLASH_AUDIO_PLAYER_PEAK_EN
      , .peak(peak)
`endif
    );

    logic [15:0] mem [$];
    logic [15:0] exp_l [$];
    logic [15:0] exp_r [$];
    int          idx, nexts, restarts, acc, nbuilt;
    bit          pause_rand;
    logic [15:0] exp_peak;

    // Reference sample: low DW bits of the word, placed at the top of a
    // 16-bit word, then divided by 2^vs rounding toward minus infinity.
    function automatic logic [15:0] xf(input logic [15:0] w, input int vs);
      logic [DW-1:0]      d;
      logic signed [15:0] a;
      d = w[DW-1:0];
      a = 16'(d) << (16 - DW);
      return a >>> vs;
    endfunction

    function automatic logic [15:0] mag(input logic [15:0] v);
      if (v == 16'h8000) return 16'h7fff;
      return v[15] ? (~v + 16'd1) : v;
    endfunction

    // Expected codec writes: frames from the word list, every second frame
    // dropped at double speed, each frame twice at half speed.
    task automatic build(input int spd, input int vs, input int laps);
      int nf, s;
      logic [15:0] l, r;
      nf = ST ? mem.size() / 2 : mem.size();
      s = (spd == 3) ? 0 : spd;
      exp_peak = 16'h0;
      nbuilt = 0;
      for (int lap = 0; lap < laps; lap++)
        for (int i = 0; i < nf; i++) begin
          if (s == 2 && (i % 2) == 1) continue;
          l = xf(mem[ST ? 2*i : i], vs);
          r = xf(mem[ST ? 2*i+1 : i], vs);
          for (int c = 0; c < ((s == 1) ? 2 : 1); c++) begin
            exp_l.push_back(l);
            exp_r.push_back(r);
            nbuilt++;
          end
          if (mag(l) > exp_peak) exp_peak = mag(l);
          if (mag(r) > exp_peak) exp_peak = mag(r);
        end
    endtask

    // Flash reader: one word per fl_next after a random 0..2 cycle gap.
    initial begin
      int dly;
      logic prev_rs;
      logic [15:0] w;
      dly = 0; prev_rs = 1'b0;
      fl_valid = 1'b0; fl_done = 1'b0; fl_data = '0;
      forever begin
        @(negedge CLOCK_50);
        if (fl_restart) begin
          chk($sformatf("b%0d restart_one_cycle", g), prev_rs, 0);
          restarts++;
          idx = 0;
          dly = $urandom_range(0, 2);
        end
        prev_rs = fl_restart;
        if (fl_next) begin
          nexts++;
          idx++;
          dly = $urandom_range(0, 2);
        end
        if (dly > 0) begin
          dly--;
          fl_valid = 1'b0;
        end else begin
          fl_valid = 1'b1;
          fl_done  = (idx >= mem.size());
          w = fl_done ? 16'($urandom) : mem[idx];
          fl_data = w[DW-1:0];
        end
      end
    end

    // Codec FIFO: accepts a strobed write, stays busy until the strobe drops.
    initial begin
      logic [15:0] el, er;
      write_ready = 1'b1;
      forever begin
        @(negedge CLOCK_50);
        if (write_s && write_ready) begin
          acc++;
          chk($sformatf("b%0d write_expected", g), exp_l.size() != 0, 1);
          if (exp_l.size() != 0) begin
            el = exp_l.pop_front();
            er = exp_r.pop_front();
            chk($sformatf("b%0d left#%0d", g, acc), wl, el);
            chk($sformatf("b%0d right#%0d", g, acc), wr, er);
          end
          write_ready = 1'b0;
          for (int k = 0; k < 50 && write_s; k++) @(negedge CLOCK_50);
          repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
          write_ready = 1'b1;
        end
      end
    end

    initial forever begin
      @(negedge CLOCK_50);
      if (pause_rand) pause = ($urandom_range(0, 3) == 0);
    end

    task automatic setup(input int spd, input int vs, input bit lp, input int laps);
      speed = 2'(spd); vol_shift = 3'(vs); loop = lp;
      idx = 0; nexts = 0; restarts = 0; acc = 0;
      exp_l.delete(); exp_r.delete();
      build(spd, vs, laps);
      @(negedge CLOCK_50);
      start = 1'b1;
    endtask

    task automatic finish_check(input string tag);
      for (int k = 0; k < 4000 && !finished; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d %s finished", g, tag), finished, 1);
      chk($sformatf("b%0d %s writes_left", g, tag), exp_l.size(), 0);
      chk($sformatf("b%0d %s frame_count", g, tag), frame_count, nbuilt);
      chk($sformatf("b%0d %s fl_next_count", g, tag), nexts, mem.size());
      chk($sformatf("b%0d %s playing", g, tag), playing, 0);
`ifdef FLASH_AUDIO_PLAYER_PEAK_EN
      chk($sformatf("b%0d %s peak", g, tag), peak, exp_peak);
`endif
      start = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      chk($sformatf("b%0d %s finished_clear", g, tag), finished, 0);
    endtask

    task automatic play(input int spd, input int vs, input string tag);
      setup(spd, vs, 1'b0, 1);
      finish_check(tag);
    endtask

    // Session sequencer for this instance.
    initial begin
      int acc_a, hi, target, n;
      reset = 1'b1; start = 1'b0; pause = 1'b0; loop = 1'b0;
      speed = 2'b00; vol_shift = 3'd0; pause_rand = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk($sformatf("b%0d rst write_s", g), write_s, 0);
      chk($sformatf("b%0d rst fl_next", g), fl_next, 0);
      chk($sformatf("b%0d rst fl_restart", g), fl_restart, 0);
      chk($sformatf("b%0d rst playing", g), playing, 0);
      chk($sformatf("b%0d rst finished", g), finished, 0);
      chk($sformatf("b%0d rst frame_count", g), frame_count, 0);
      chk($sformatf("b%0d rst left", g), wl, 0);
      chk($sformatf("b%0d rst right", g), wr, 0);
      reset = 1'b0;
      repeat (2) @(negedge CLOCK_50);

      mem = '{16'h1234, 16'h8000};                   play(0, 0, "basic");
      mem = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; play(0, 0, "four");
      mem = '{16'h4000};                             play(1, 0, "half");
      mem = '{16'h4000, 16'h0440};                   play(1, 0, "half2");
      mem = '{16'h1111, 16'h2222, 16'h3333};         play(2, 0, "double3");
      mem = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      play(2, 1, "double6");
      mem = '{16'h8000, 16'h007F};                   play(0, 2, "vol2");
      mem = '{16'h007F, 16'h0080, 16'hFF80, 16'h7FFF}; play(3, 0, "width");
      mem = '{16'h8000, 16'h8080};                   play(0, 7, "vol7");

      // Looping: several laps, then stop via start=0.
      mem = '{16'h0101, 16'h0202, 16'h0303};
      setup(0, 0, 1'b1, 4);
      target = ST ? 3 : 7;
      for (int k = 0; k < 4000 && acc < target; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d loop frames_reached", g), acc >= target, 1);
      chk($sformatf("b%0d loop finished_low", g), finished, 0);
      start = 1'b0;
      for (int k = 0; k < 500 && playing; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d loop stopped", g), playing, 0);
      repeat (3) @(negedge CLOCK_50);
      chk($sformatf("b%0d loop finished_after", g), finished, 0);
      chk($sformatf("b%0d loop restarts", g), restarts >= 2, 1);
      chk($sformatf("b%0d loop frame_count", g), frame_count, acc);
      exp_l.delete(); exp_r.delete();

      // Pause raised while a write is outstanding.
      mem = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
      setup(0, 0, 1'b0, 1);
      for (int k = 0; k < 500 && !write_s; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d pause write_seen", g), write_s, 1);
      pause = 1'b1;
      for (int k = 0; k < 100 && write_s; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d pause write_done", g), write_s, 0);
      acc_a = acc;
      hi = 0;
      repeat (30) begin
        @(negedge CLOCK_50);
        if (write_s) hi++;
      end
      chk($sformatf("b%0d pause held_writes", g), hi, 0);
      chk($sformatf("b%0d pause accepted", g), acc, acc_a);
      chk($sformatf("b%0d pause frame_count", g), frame_count, acc_a);
      pause = 1'b0;
      finish_check("pause");

      // Reset while a write strobe is high.
      mem = '{16'h1357, 16'h2468, 16'h3579, 16'h468A};
      setup(0, 0, 1'b0, 1);
      for (int k = 0; k < 500 && !write_s; k++) @(negedge CLOCK_50);
      chk($sformatf("b%0d midrst write_seen", g), write_s, 1);
      #2 reset = 1'b1;
      #1;
      chk($sformatf("b%0d midrst write_s", g), write_s, 0);
      chk($sformatf("b%0d midrst playing", g), playing, 0);
      chk($sformatf("b%0d midrst frame_count", g), frame_count, 0);
      chk($sformatf("b%0d midrst fl_next", g), fl_next, 0);
      start = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b0;
      exp_l.delete(); exp_r.delete();
      repeat (6) @(negedge CLOCK_50);
      mem = '{16'h7001, 16'h7002};                   play(0, 1, "after_rst");

      // Random sessions, optionally with random pause activity.
      for (int t = 0; t < 10; t++) begin
        n = $urandom_range(1, 6);
        mem.delete();
        for (int i = 0; i < n; i++) mem.push_back(16'($urandom));
        pause_rand = $urandom_range(0, 1);
        play($urandom_range(0, 3), $urandom_range(0, 7), $sformatf("rand%0d", t));
        pause_rand = 1'b0;
        pause = 1'b0;
      end

      blk_done[g] = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 90000 && !(blk_done[0] && blk_done[1]); k++) @(negedge CLOCK_50);
    if (!(blk_done[0] && blk_done[1])) begin
      n_chk++;
      n_fail++;
      $display("FAIL global_timeout: done=%0d%0d required=11", blk_done[0], blk_done[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
